// File: rtl/mm_buf_router.sv
// mm_buf_router: steers the MM core's input-read, accumulate-read and
// output-write ports onto NUM_BUF feature buffers. Buffer selection is latched
// from the instruction at ap_start and validated before the core is started.
// Outstanding reads are tracked per core read port so that ap_done only fires
// once every return has drained.
module mm_buf_router #(
  parameter int                 NUM_BUF     = 4,
  parameter int                 DATA_W      = 512,
  parameter int                 ADDR_W      = 11,
  parameter int                 INST_W      = 128,
  parameter int                 IN_SEL_LSB  = 1,
  parameter int                 OUT_SEL_LSB = 7,
  parameter int                 ACC_BIT     = 13,
  parameter logic [NUM_BUF-1:0] WR_MASK     = 4'b1100,
  parameter int                 MAX_OUTST   = 8
) (
  input  logic                        kernal_clk,
  input  logic                        kernal_rst,
  input  logic [INST_W-1:0]           ctrl_instruction,
  input  logic                        ap_start,
  output logic                        ap_done,
  output logic                        ap_err,
  output logic                        busy,
  output logic                        core_start,
  input  logic                        core_done,
  input  logic                        core_in_avalid,
  input  logic [ADDR_W-1:0]           core_in_addr,
  output logic                        core_in_valid,
  output logic [DATA_W-1:0]           core_in_data,
  input  logic                        core_acc_avalid,
  input  logic [ADDR_W-1:0]           core_acc_addr,
  output logic                        core_acc_valid,
  output logic [DATA_W-1:0]           core_acc_data,
  input  logic                        core_out_valid,
  input  logic [ADDR_W-1:0]           core_out_addr,
  input  logic [DATA_W-1:0]           core_out_data,
  output logic [NUM_BUF-1:0]          buf_rd_avalid,
  output logic [NUM_BUF*ADDR_W-1:0]   buf_rd_addr,
  input  logic [NUM_BUF-1:0]          buf_rd_valid,
  input  logic [NUM_BUF*DATA_W-1:0]   buf_rd_data,
  output logic [NUM_BUF-1:0]          buf_wr_valid,
  output logic [NUM_BUF*ADDR_W-1:0]   buf_wr_addr,
  output logic [NUM_BUF*DATA_W-1:0]   buf_wr_data
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RUN, S_DRAIN} state_t;

  state_t               state, state_nxt;
  logic [NUM_BUF-1:0]   in_sel, out_sel;
  logic                 acc_en;
  logic [CNT_W-1:0]     in_cnt, acc_cnt;
  logic [CNT_W-1:0]     in_cnt_nxt, acc_cnt_nxt;
  logic                 in_ovf, acc_ovf;
  logic                 fault, fault_nxt;
  logic                 go_check, accept, reject, finish;
  logic                 in_req, acc_req, wr_fwd, routing;
  logic                 in_ret, acc_ret, drained, cfg_ok;
  logic [DATA_W-1:0]    in_mux, acc_mux;

  logic [NUM_BUF-1:0]        rd_avalid_p1;
  logic [NUM_BUF*ADDR_W-1:0] rd_addr_p1;
  logic [NUM_BUF-1:0]        wr_vld_p1;
  logic [NUM_BUF*ADDR_W-1:0] wr_addr_p1;
  logic [NUM_BUF*DATA_W-1:0] wr_data_p1;
  logic                      in_vld_p1, acc_vld_p1;
  logic [DATA_W-1:0]         in_data_p1, acc_data_p1;

  // Only the select/acc fields matter; the rest of the word is deliberately ignored.
  logic unused_inst_bits;
  assign unused_inst_bits = ^ctrl_instruction;

  // Saturating outstanding-count update; MSB of the result flags an
  // overflow (request beyond MAX_OUTST) or an unsolicited return at zero.
  function automatic logic [CNT_W:0] outst_next(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic dec);
    logic [CNT_W-1:0] n;
    logic             flt;
    n   = cnt;
    flt = 1'b0;
    if (inc && !dec) begin
      if (cnt == CNT_W'(MAX_OUTST)) flt = 1'b1;
      else                          n   = cnt + 1'b1;
    end else if (dec && !inc) begin
      if (cnt == '0) flt = 1'b1;
      else           n   = cnt - 1'b1;
    end else if (inc && dec) begin
      if (cnt == '0) flt = 1'b1;
    end
    return {flt, n};
  endfunction

  function automatic logic is_onehot(input logic [NUM_BUF-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  assign routing = (state == S_RUN) || (state == S_DRAIN);
  assign in_req  = core_in_avalid && (state == S_RUN);
  assign acc_req = core_acc_avalid && acc_en && (state == S_RUN);
  assign wr_fwd  = core_out_valid && routing;
  assign in_ret  = routing && |(buf_rd_valid & in_sel);
  assign acc_ret = routing && acc_en && |(buf_rd_valid & out_sel);

  assign {in_ovf, in_cnt_nxt}   = outst_next(in_cnt, in_req, in_ret);
  assign {acc_ovf, acc_cnt_nxt} = outst_next(acc_cnt, acc_req, acc_ret);
  assign fault_nxt = fault | in_ovf | acc_ovf;
  assign drained   = (in_cnt_nxt == '0) && (acc_cnt_nxt == '0);

  assign cfg_ok = is_onehot(in_sel) && is_onehot(out_sel) &&
                  ((out_sel & ~WR_MASK) == '0) &&
                  !(acc_en && (in_sel == out_sel));

  assign busy = (state != S_IDLE);

  // Next-state and one-cycle control events for the start/check/run/drain sequence.
  always_comb begin
    state_nxt = state;
    go_check  = 1'b0;
    accept    = 1'b0;
    reject    = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE: begin
        if (ap_start) begin
          state_nxt = S_CHECK;
          go_check  = 1'b1;
        end
      end
      S_CHECK: begin
        if (cfg_ok) begin
          state_nxt = S_RUN;
          accept    = 1'b1;
        end else begin
          state_nxt = S_IDLE;
          reject    = 1'b1;
        end
      end
      S_RUN: begin
        if (core_done) begin
          if (drained) begin
            state_nxt = S_IDLE;
            finish    = 1'b1;
          end else begin
            state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (drained) begin
          state_nxt = S_IDLE;
          finish    = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control state: FSM, latched selects, outstanding counters, fault and handshake outputs.
  always_ff @(posedge kernal_clk) begin
    if (kernal_rst) begin
      state      <= S_IDLE;
      in_sel     <= '0;
      out_sel    <= '0;
      acc_en     <= 1'b0;
      in_cnt     <= '0;
      acc_cnt    <= '0;
      fault      <= 1'b0;
      core_start <= 1'b0;
      ap_done    <= 1'b0;
      ap_err     <= 1'b0;
    end else begin
      state      <= state_nxt;
      core_start <= accept;
      ap_done    <= reject | finish;
      if (go_check) begin
        in_sel  <= ctrl_instruction[IN_SEL_LSB +: NUM_BUF];
        out_sel <= ctrl_instruction[OUT_SEL_LSB +: NUM_BUF];
        acc_en  <= ctrl_instruction[ACC_BIT];
      end
      if (accept) begin
        in_cnt  <= '0;
        acc_cnt <= '0;
        fault   <= 1'b0;
        ap_err  <= 1'b0;
      end else begin
        in_cnt  <= in_cnt_nxt;
        acc_cnt <= acc_cnt_nxt;
        fault   <= fault_nxt;
        if (reject)      ap_err <= 1'b1;
        else if (finish) ap_err <= fault_nxt;
      end
    end
  end

  // Return-data select from the latched one-hot selects.
  always_comb begin
    in_mux  = '0;
    acc_mux = '0;
    for (int i = 0; i < NUM_BUF; i++) begin
      if (in_sel[i])  in_mux  = in_mux  | buf_rd_data[i*DATA_W +: DATA_W];
      if (out_sel[i]) acc_mux = acc_mux | buf_rd_data[i*DATA_W +: DATA_W];
    end
  end

  // Stage p0 -> p1: core read requests steered to the selected buffer lanes.
  always_ff @(posedge kernal_clk) begin
    if (kernal_rst) begin
      rd_avalid_p1 <= '0;
      rd_addr_p1   <= '0;
    end else begin
      for (int i = 0; i < NUM_BUF; i++) begin
        if (in_req && in_sel[i]) begin
          rd_avalid_p1[i]                 <= 1'b1;
          rd_addr_p1[i*ADDR_W +: ADDR_W]  <= core_in_addr;
        end else if (acc_req && out_sel[i]) begin
          rd_avalid_p1[i]                 <= 1'b1;
          rd_addr_p1[i*ADDR_W +: ADDR_W]  <= core_acc_addr;
        end else begin
          rd_avalid_p1[i]                 <= 1'b0;
          rd_addr_p1[i*ADDR_W +: ADDR_W]  <= '0;
        end
      end
    end
  end

  // Stage p0 -> p1: core writes steered to the output-select buffer lane only.
  always_ff @(posedge kernal_clk) begin
    if (kernal_rst) begin
      wr_vld_p1  <= '0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
    end else begin
      for (int i = 0; i < NUM_BUF; i++) begin
        if (wr_fwd && out_sel[i]) begin
          wr_vld_p1[i]                    <= 1'b1;
          wr_addr_p1[i*ADDR_W +: ADDR_W]  <= core_out_addr;
          wr_data_p1[i*DATA_W +: DATA_W]  <= core_out_data;
        end else begin
          wr_vld_p1[i]                    <= 1'b0;
          wr_addr_p1[i*ADDR_W +: ADDR_W]  <= '0;
          wr_data_p1[i*DATA_W +: DATA_W]  <= '0;
        end
      end
    end
  end

  // Stage p0 -> p1: buffer returns routed back to the core read ports.
  always_ff @(posedge kernal_clk) begin
    if (kernal_rst) begin
      in_vld_p1   <= 1'b0;
      in_data_p1  <= '0;
      acc_vld_p1  <= 1'b0;
      acc_data_p1 <= '0;
    end else begin
      in_vld_p1   <= in_ret;
      in_data_p1  <= in_ret ? in_mux : '0;
      acc_vld_p1  <= acc_ret;
      acc_data_p1 <= acc_ret ? acc_mux : '0;
    end
  end

  assign buf_rd_avalid  = rd_avalid_p1;
  assign buf_rd_addr    = rd_addr_p1;
  assign buf_wr_valid   = wr_vld_p1;
  assign buf_wr_addr    = wr_addr_p1;
  assign buf_wr_data    = wr_data_p1;
  assign core_in_valid  = in_vld_p1;
  assign core_in_data   = in_data_p1;
  assign core_acc_valid = acc_vld_p1;
  assign core_acc_data  = acc_data_p1;

endmodule
